// File: rtl/stream_mux_n_if.sv
// rtl/stream_mux_n_if.sv - handshake bundle between N producers, the stream mux and one consumer
interface stream_mux_n_if #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_IN    = 4,
    parameter int SEL_W     = 2
) ();
    logic [NUM_IN*WORD_SIZE-1:0] in_data;
    logic [NUM_IN-1:0]           in_valid;
    logic [NUM_IN-1:0]           in_ready;
    logic [SEL_W-1:0]            sel;
    logic [WORD_SIZE-1:0]        out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [SEL_W-1:0]            out_ch;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/stream_mux_n.sv
// rtl/stream_mux_n.sv - N-input registered stream mux, external select or round-robin
module stream_mux_n #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_IN    = 4,
    parameter int SEL_W     = 2,
    parameter bit RR_MODE   = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_mux_n_if.slave bus
);
    logic [WORD_SIZE-1:0] out_data_q;
    logic                 out_valid_q;
    logic [SEL_W-1:0]     out_ch_q;
    logic [SEL_W-1:0]     rr_ptr;

    logic                 load;
    logic                 grant_ok;
    logic [SEL_W-1:0]     grant;
    logic [NUM_IN-1:0]    ready;
    int                   idx;

    assign load = !out_valid_q || bus.out_ready;

    // Round-robin scans downward so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_ok = 1'b0;
        grant    = '0;
        idx      = 0;
        if (RR_MODE) begin
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr) + k) % NUM_IN;
                if (bus.in_valid[SEL_W'(idx)]) begin
                    grant_ok = 1'b1;
                    grant    = SEL_W'(idx);
                end
            end
        end else if (int'(bus.sel) < NUM_IN) begin
            if (bus.in_valid[bus.sel]) begin
                grant_ok = 1'b1;
                grant    = bus.sel;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (rst_n && load && grant_ok) begin
            ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            if (grant_ok) begin
                out_data_q  <= bus.in_data[int'(grant)*WORD_SIZE +: WORD_SIZE];
                out_ch_q    <= grant;
                out_valid_q <= 1'b1;
                if (RR_MODE) begin
                    rr_ptr <= (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
endmodule
